// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF input synchronizer, mid-bit sampling FSM and a
// valid/ready output holding register with framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned BIT_CLK = 87
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [7:0] HALF_LAST = 8'(BIT_CLK / 2 - 1);
    localparam logic [7:0] BIT_LAST  = 8'(BIT_CLK - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [2:0] idx_q;
    logic [7:0] shreg_q;
    logic       sync1_q;
    logic       sync2_q;
    logic       commit_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       frame_err_q;
    logic       overrun_q;
    logic       sample;

    // START samples after half a bit; DATA/STOP sample once per full bit.
    always_comb begin
        sample = 1'b0;
        if (state_q == S_START) begin
            sample = (cnt_q == HALF_LAST);
        end else begin
            sample = (cnt_q == BIT_LAST);
        end
        cnt_d = sample ? '0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            commit_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            commit_q    <= 1'b0;

            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            // Commit lands one cycle after the stop sample; an accept in the
            // same cycle frees the holding register for the new byte.
            if (commit_q) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q  <= shreg_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (!sync2_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    cnt_q <= cnt_d;
                    if (sample) begin
                        state_q <= sync2_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_d;
                    if (sample) begin
                        shreg_q <= {sync2_q, shreg_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    cnt_q <= cnt_d;
                    if (sample) begin
                        if (sync2_q) begin
                            commit_q <= 1'b1;
                            state_q  <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BIT_CLK=87: line driven by a bit-accurate
// serial model, accepted bytes and flag pulses collected by a monitor.
module tb_uart_rx;

    localparam int unsigned BIT = 87;

    logic       clk;
    logic       reset_n;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int checks;
    int passes;
    int fe_cnt;
    int ov_cnt;
    logic [7:0] acc_q[$];

    uart_rx #(.BIT_CLK(BIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepts happen at the posedge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic clear_log();
        acc_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rx_valid); else passes++;
        checks++; if (rx_data !== 8'h00) $display("FAIL reset_data got %h exp 00", rx_data); else passes++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got %b exp 0", frame_err); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_ovr got %b exp 0", overrun); else passes++;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single();
        int k;
        clear_log();
        rx_ready = 1'b1;
        k = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (!rx_valid && k < 1000) begin
                    @(negedge clk);
                    k++;
                end
                checks++; if (k !== 830) $display("FAIL single_latency got %0d exp 830", k); else passes++;
                checks++; if (rx_data !== 8'hA5) $display("FAIL single_data got %h exp a5", rx_data); else passes++;
                @(negedge clk);
                checks++; if (rx_valid !== 1'b0) $display("FAIL single_one_cycle got %b exp 0", rx_valid); else passes++;
            end
        join
        repeat (20) @(negedge clk);
        checks++; if (acc_q.size() !== 1) $display("FAIL single_count got %0d exp 1", acc_q.size()); else passes++;
        checks++; if (fe_cnt + ov_cnt !== 0) $display("FAIL single_flags got %0d exp 0", fe_cnt + ov_cnt); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        exp_b = '{8'h00, 8'hFF, 8'h5A};
        clear_log();
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(exp_b[i], 1'b1);
        repeat (100) @(negedge clk);
        checks++; if (acc_q.size() !== 3) $display("FAIL b2b_count got %0d exp 3", acc_q.size()); else passes++;
        for (int i = 0; i < 3; i++) begin
            if (i < acc_q.size()) begin
                checks++;
                if (acc_q[i] !== exp_b[i]) $display("FAIL b2b_byte%0d got %h exp %h", i, acc_q[i], exp_b[i]);
                else passes++;
            end
        end
        checks++; if (fe_cnt + ov_cnt !== 0) $display("FAIL b2b_flags got %0d exp 0", fe_cnt + ov_cnt); else passes++;
    endtask

    task automatic test_glitch();
        clear_log();
        rxd = 1'b0;
        repeat (30) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (acc_q.size() !== 0) $display("FAIL glitch_valid got %0d exp 0", acc_q.size()); else passes++;
        checks++; if (fe_cnt !== 0) $display("FAIL glitch_ferr got %0d exp 0", fe_cnt); else passes++;
        send_byte(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (acc_q.size() !== 1 || acc_q[0] !== 8'h3C) $display("FAIL glitch_next got n=%0d b=%h exp n=1 b=3c", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 8'hxx);
        else passes++;
    endtask

    task automatic test_break();
        clear_log();
        send_byte(8'h81, 1'b0);
        repeat (2000) @(negedge clk);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (fe_cnt !== 1) $display("FAIL break_ferr_count got %0d exp 1", fe_cnt); else passes++;
        checks++; if (acc_q.size() !== 0 || rx_valid !== 1'b0) $display("FAIL break_valid got n=%0d v=%b exp 0", acc_q.size(), rx_valid); else passes++;
        send_byte(8'h96, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (acc_q.size() !== 1 || acc_q[0] !== 8'h96) $display("FAIL break_next got n=%0d b=%h exp n=1 b=96", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 8'hxx);
        else passes++;
    endtask

    task automatic test_overrun();
        clear_log();
        rx_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid got %b exp 1", rx_valid); else passes++;
        checks++; if (rx_data !== 8'h11) $display("FAIL ovr_data got %h exp 11", rx_data); else passes++;
        checks++; if (ov_cnt !== 1) $display("FAIL ovr_pulses got %0d exp 1", ov_cnt); else passes++;
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) $display("FAIL ovr_drain got %b exp 0", rx_valid); else passes++;
        checks++;
        if (acc_q.size() !== 1 || acc_q[0] !== 8'h11) $display("FAIL ovr_accept got n=%0d b=%h exp n=1 b=11", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 8'hxx);
        else passes++;
    endtask

    task automatic test_reset_mid();
        clear_log();
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        send_byte(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) $display("FAIL rst_pre got v=%b d=%h exp v=1 d=5a", rx_valid, rx_data); else passes++;
        // 0xF0: reset lands in bit 5, so the rest of the frame is all ones.
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (540) @(negedge clk);
                reset_n = 1'b0;
                @(negedge clk);
                checks++;
                if ({rx_valid, rx_data, frame_err, overrun} !== 11'd0)
                    $display("FAIL rst_outputs got v=%b d=%h fe=%b ov=%b exp all 0", rx_valid, rx_data, frame_err, overrun);
                else passes++;
                reset_n = 1'b1;
            end
        join
        repeat (50) @(negedge clk);
        checks++; if (acc_q.size() !== 0 || rx_valid !== 1'b0 || fe_cnt !== 0) $display("FAIL rst_ignored got n=%0d v=%b fe=%0d exp 0", acc_q.size(), rx_valid, fe_cnt); else passes++;
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(negedge clk);
        send_byte(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (acc_q.size() !== 1 || acc_q[0] !== 8'hC3) $display("FAIL rst_next got n=%0d b=%h exp n=1 b=c3", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 8'hxx);
        else passes++;
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        fe_cnt   = 0;
        ov_cnt   = 0;
        reset_n  = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
